// File: rtl/mdma_wrb_ctxt_ram_ctrl_pkg.sv
// mdma_wrb_ctxt_pkg: shared constants and types for the writeback-context RAM
// controller. The constants fix the RAM geometry and the pidx field width. The
// package also holds the FSM state and requester-id enums, and a helper that
// overwrites the pidx field inside an entry.
package mdma_wrb_ctxt_pkg;

  localparam int WRB_CTXT_RAM_DEPTH     = 2048;
  localparam int WRB_CTXT_RAM_DATA_BITS = 128;
  localparam int WRB_CTXT_AW            = $clog2(WRB_CTXT_RAM_DEPTH);
  localparam int WRB_CTXT_DW            = WRB_CTXT_RAM_DATA_BITS;
  localparam int PIDX_BITS              = 16;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RD_WAIT = 2'd1,
    ST_RMW_WR  = 2'd2
  } ctxt_state_e;

  typedef enum logic {
    REQ_A = 1'b0,
    REQ_B = 1'b1
  } req_id_e;

  function automatic logic [WRB_CTXT_DW-1:0] pidx_merge(
    input logic [WRB_CTXT_DW-1:0] entry,
    input logic [PIDX_BITS-1:0]   pidx,
    input int                     lsb
  );
    logic [WRB_CTXT_DW-1:0] r;
    r = entry;
    r[lsb +: PIDX_BITS] = pidx;
    return r;
  endfunction

endpackage

// File: rtl/mdma_wrb_ctxt_ram_ctrl_if.sv
// mdma_128bx2048_128bwe_ram_if: port bundle of the 2048 x 128b context RAM.
//   m (controller side): drives wadr, wen, wdat, ren, radr; receives rdat, rsbe, rdbe
//   s (RAM side):        the mirror image
interface mdma_128bx2048_128bwe_ram_if;
  import mdma_wrb_ctxt_pkg::*;

  logic [WRB_CTXT_AW-1:0] wadr;
  logic                   wen;
  logic [WRB_CTXT_DW-1:0] wdat;
  logic                   ren;
  logic [WRB_CTXT_AW-1:0] radr;
  logic [WRB_CTXT_DW-1:0] rdat;
  logic                   rsbe;
  logic                   rdbe;

  modport m (output wadr, wen, wdat, ren, radr, input rdat, rsbe, rdbe);
  modport s (input wadr, wen, wdat, ren, radr, output rdat, rsbe, rdbe);

endinterface

// File: rtl/mdma_wrb_ctxt_ram_ctrl_rr_arb2.sv
// mdma_rr_arb2: two-way round-robin grant.
//   clk, rst      : clock, synchronous active-high reset
//   en            : grants may be issued this cycle
//   req_a, req_b  : requests
//   gnt_a, gnt_b  : one-hot grant, combinational from the requests
// Grants are combinational from the requests and are accepted in the same
// cycle. The pointer therefore tracks the last requester granted. Reset leaves
// it pointing at B, so A wins the first contended cycle.
module mdma_rr_arb2
  import mdma_wrb_ctxt_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic req_a,
  input  logic req_b,
  output logic gnt_a,
  output logic gnt_b
);

  req_id_e last_q;

  always_comb begin
    gnt_a = 1'b0;
    gnt_b = 1'b0;
    if (en) begin
      if (req_a && req_b) begin
        gnt_a = (last_q == REQ_B);
        gnt_b = (last_q == REQ_A);
      end else begin
        gnt_a = req_a;
        gnt_b = req_b;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst)        last_q <= REQ_B;
    else if (gnt_a) last_q <= REQ_A;
    else if (gnt_b) last_q <= REQ_B;
  end

endmodule

// File: rtl/mdma_wrb_ctxt_ram_ctrl.sv
// mdma_wrb_ctxt_ram_ctrl: sole owner of the writeback-context RAM. It serialises
// two requesters and keeps one operation outstanding at a time:
//   port A (a_*): full-entry read/write; a_rvld/a_rdat return read data
//   port B (b_*): atomic read-modify-write of the pidx field; b_done/b_old
//                 report completion and the pre-update entry
//   ram         : RAM master modport
//   clk, rst    : clock, synchronous active-high reset
// Optional MDMA_WRB_CTXT_RAM_ECC_ERR_EN adds these ports:
//   sbe_cnt : saturating count of single-bit errors
//   dbe_err : sticky double-bit-error flag
//   dbe_adr : address of the first double-bit error
//   err_clr : clears all three
// With this option, a DBE on a B read suppresses that write-back.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_IDLE    | grants issued here; A writes complete in the grant cycle
// ST_RD_WAIT | RAM read in flight; the down-counter reaching 0 marks rdat valid
// ST_RMW_WR  | B write-back of the merged entry, b_done pulse
module mdma_wrb_ctxt_ram_ctrl
  import mdma_wrb_ctxt_pkg::*;
#(
  parameter int RD_LAT   = 2,
  parameter int PIDX_LSB = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   a_vld,
  output logic                   a_rdy,
  input  logic                   a_we,
  input  logic [WRB_CTXT_AW-1:0] a_adr,
  input  logic [WRB_CTXT_DW-1:0] a_wdat,
  output logic                   a_rvld,
  output logic [WRB_CTXT_DW-1:0] a_rdat,
  input  logic                   b_vld,
  output logic                   b_rdy,
  input  logic [WRB_CTXT_AW-1:0] b_adr,
  input  logic [PIDX_BITS-1:0]   b_pidx,
  output logic                   b_done,
  output logic [WRB_CTXT_DW-1:0] b_old,
`ifdef MDMA_WRB_CTXT_RAM_ECC_ERR_EN
  output logic [15:0]            sbe_cnt,
  output logic                   dbe_err,
  output logic [WRB_CTXT_AW-1:0] dbe_adr,
  input  logic                   err_clr,
`endif
  mdma_128bx2048_128bwe_ram_if.m ram
);

  ctxt_state_e            state_q, state_d;
  logic [1:0]             cnt_q;
  req_id_e                op_q;
  logic [WRB_CTXT_AW-1:0] adr_q;
  logic [PIDX_BITS-1:0]   pidx_q;
  logic                   idle, gnt_a, gnt_b, rd_cap, wb_sup;

  assign idle   = (state_q == ST_IDLE) && !rst;
  assign rd_cap = (state_q == ST_RD_WAIT) && (cnt_q == 2'd0);

  mdma_rr_arb2 u_arb (
    .clk   (clk),
    .rst   (rst),
    .en    (idle),
    .req_a (a_vld),
    .req_b (b_vld),
    .gnt_a (gnt_a),
    .gnt_b (gnt_b)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:    if ((gnt_a && !a_we) || gnt_b) state_d = ST_RD_WAIT;
      ST_RD_WAIT: if (rd_cap) state_d = (op_q == REQ_B) ? ST_RMW_WR : ST_IDLE;
      ST_RMW_WR:  state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    a_rdy     = gnt_a;
    b_rdy     = gnt_b;
    b_done    = 1'b0;
    ram.ren   = 1'b0;
    ram.wen   = 1'b0;
    ram.radr  = gnt_b ? b_adr : a_adr;
    ram.wadr  = a_adr;
    ram.wdat  = a_wdat;
    if (state_q == ST_IDLE) begin
      ram.ren = gnt_b || (gnt_a && !a_we);
      ram.wen = gnt_a && a_we;
    end else if (state_q == ST_RMW_WR && !rst) begin
      b_done   = 1'b1;
      ram.wen  = !wb_sup;
      ram.wadr = adr_q;
      ram.wdat = pidx_merge(b_old, pidx_q, PIDX_LSB);
    end
  end

  // b_old doubles as the RMW capture register, so the merge source and the
  // reported pre-update entry are the same value by construction.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= 2'd0;
      op_q   <= REQ_A;
      adr_q  <= '0;
      pidx_q <= '0;
      a_rvld <= 1'b0;
      a_rdat <= '0;
      b_old  <= '0;
    end else begin
      a_rvld <= 1'b0;
      if (state_q == ST_IDLE) begin
        cnt_q <= 2'(RD_LAT - 1);
        if (gnt_a) begin
          op_q  <= REQ_A;
          adr_q <= a_adr;
        end else if (gnt_b) begin
          op_q   <= REQ_B;
          adr_q  <= b_adr;
          pidx_q <= b_pidx;
        end
      end else if (state_q == ST_RD_WAIT) begin
        if (rd_cap) begin
          if (op_q == REQ_A) begin
            a_rdat <= ram.rdat;
            a_rvld <= 1'b1;
          end else begin
            b_old <= ram.rdat;
          end
        end else begin
          cnt_q <= cnt_q - 2'd1;
        end
      end
    end
  end

`ifdef MDMA_WRB_CTXT_RAM_ECC_ERR_EN
  always_ff @(posedge clk) begin
    if (rst || err_clr) begin
      sbe_cnt <= '0;
      dbe_err <= 1'b0;
      dbe_adr <= '0;
    end else if (rd_cap) begin
      if (ram.rsbe && sbe_cnt != 16'hFFFF) sbe_cnt <= sbe_cnt + 16'd1;
      if (ram.rdbe && !dbe_err) begin
        dbe_err <= 1'b1;
        dbe_adr <= adr_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst)         wb_sup <= 1'b0;
    else if (rd_cap) wb_sup <= ram.rdbe;
  end
`else
  logic unused_ecc;
  assign unused_ecc = ram.rsbe ^ ram.rdbe;
  assign wb_sup     = 1'b0;
`endif

endmodule

// File: tb/tb_mdma_wrb_ctxt_ram_ctrl.sv
// Scoreboard bench for mdma_wrb_ctxt_ram_ctrl. The reference model is a plain
// array of entries. It is updated when a grant is observed, and it queues the
// expected response and its due cycle. A monitor process pops and compares.
module tb_mdma_wrb_ctxt_ram_ctrl;
  import mdma_wrb_ctxt_pkg::*;

  localparam int RD_LAT   = 2;
  localparam int PIDX_LSB = 0;
  localparam int AW       = WRB_CTXT_AW;
  localparam int DW       = WRB_CTXT_DW;

  typedef struct { logic [DW-1:0] dat; int cyc; } a_exp_t;
  typedef struct { logic [DW-1:0] old; logic [DW-1:0] nv; logic [AW-1:0] adr; logic wen; int cyc; } b_exp_t;

  logic clk = 1'b0;
  logic rst;
  logic a_vld, a_rdy, a_we, a_rvld;
  logic [AW-1:0] a_adr;
  logic [DW-1:0] a_wdat, a_rdat;
  logic b_vld, b_rdy, b_done;
  logic [AW-1:0] b_adr;
  logic [15:0] b_pidx;
  logic [DW-1:0] b_old;
`ifdef MDMA_WRB_CTXT_RAM_ECC_ERR_EN
  logic [15:0] sbe_cnt;
  logic dbe_err, err_clr;
  logic [AW-1:0] dbe_adr;
`endif

  mdma_128bx2048_128bwe_ram_if ram_if ();

  mdma_wrb_ctxt_ram_ctrl #(.RD_LAT(RD_LAT), .PIDX_LSB(PIDX_LSB)) dut (
    .clk(clk), .rst(rst),
    .a_vld(a_vld), .a_rdy(a_rdy), .a_we(a_we), .a_adr(a_adr), .a_wdat(a_wdat),
    .a_rvld(a_rvld), .a_rdat(a_rdat),
    .b_vld(b_vld), .b_rdy(b_rdy), .b_adr(b_adr), .b_pidx(b_pidx),
    .b_done(b_done), .b_old(b_old),
`ifdef MDMA_WRB_CTXT_RAM_ECC_ERR_EN
    .sbe_cnt(sbe_cnt), .dbe_err(dbe_err), .dbe_adr(dbe_adr), .err_clr(err_clr),
`endif
    .ram(ram_if)
  );

  always #5 clk = ~clk;

  // RAM model: write on wen, RD_LAT-deep read pipeline, injectable ECC flags
  logic [DW-1:0] ram_mem [WRB_CTXT_RAM_DEPTH];
  logic [DW-1:0] rd_pipe [RD_LAT];
  logic sbe_pipe [RD_LAT];
  logic dbe_pipe [RD_LAT];
  logic init_we, inj_sbe, inj_dbe;
  logic [AW-1:0] init_adr;
  logic [DW-1:0] init_dat;

  always @(posedge clk) begin
    if (init_we) ram_mem[init_adr] <= init_dat;
    else if (ram_if.wen) ram_mem[ram_if.wadr] <= ram_if.wdat;
    rd_pipe[0]  <= ram_mem[ram_if.radr];
    sbe_pipe[0] <= ram_if.ren & inj_sbe;
    dbe_pipe[0] <= ram_if.ren & inj_dbe;
    for (int i = 1; i < RD_LAT; i++) begin
      rd_pipe[i]  <= rd_pipe[i-1];
      sbe_pipe[i] <= sbe_pipe[i-1];
      dbe_pipe[i] <= dbe_pipe[i-1];
    end
  end
  assign ram_if.rdat = rd_pipe[RD_LAT-1];
  assign ram_if.rsbe = sbe_pipe[RD_LAT-1];
  assign ram_if.rdbe = dbe_pipe[RD_LAT-1];

  logic [DW-1:0] ref_mem [WRB_CTXT_RAM_DEPTH];
  a_exp_t exp_a [$];
  b_exp_t exp_b [$];
  bit     gnt_seq [$];
  int n_chk = 0, n_fail = 0, cyc = 0, overlap_cnt = 0;
  logic quiet = 1'b0;

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // grant tracker: reference model update and expectation push
  initial forever begin
    b_exp_t e;
    @(negedge clk);
    if (!rst) begin
      if (ram_if.ren && ram_if.wen) overlap_cnt++;
      if (a_vld && a_rdy) begin
        gnt_seq.push_back(1'b0);
        if (a_we) begin
          chk("a_wr_wen", {127'd0, ram_if.wen}, 1);
          chk("a_wr_wadr", ram_if.wadr, a_adr);
          chk("a_wr_wdat", ram_if.wdat, a_wdat);
          ref_mem[a_adr] = a_wdat;
        end else begin
          chk("a_rd_ren", {127'd0, ram_if.ren}, 1);
          chk("a_rd_radr", ram_if.radr, a_adr);
          exp_a.push_back('{dat: ref_mem[a_adr], cyc: cyc + RD_LAT + 1});
        end
      end
      if (b_vld && b_rdy) begin
        gnt_seq.push_back(1'b1);
        chk("b_rd_ren", {127'd0, ram_if.ren}, 1);
        chk("b_rd_radr", ram_if.radr, b_adr);
        e.old = ref_mem[b_adr];
        e.nv  = e.old;
        e.nv[PIDX_LSB +: 16] = b_pidx;
        e.adr = b_adr;
        e.cyc = cyc + RD_LAT + 1;
`ifdef MDMA_WRB_CTXT_RAM_ECC_ERR_EN
        e.wen = !inj_dbe;
`else
        e.wen = 1'b1;
`endif
        if (e.wen) ref_mem[b_adr] = e.nv;
        exp_b.push_back(e);
      end
    end
  end

  // response monitor
  initial forever begin
    a_exp_t ea;
    b_exp_t eb;
    @(negedge clk);
    if (a_rvld) begin
      chk("a_rvld_expected", {127'd0, exp_a.size() != 0}, 1);
      if (exp_a.size() != 0) begin
        ea = exp_a.pop_front();
        chk("a_rdat", a_rdat, ea.dat);
        chk("a_rvld_cycle", cyc, ea.cyc);
      end
    end
    if (b_done) begin
      chk("b_done_expected", {127'd0, exp_b.size() != 0}, 1);
      if (exp_b.size() != 0) begin
        eb = exp_b.pop_front();
        chk("b_old", b_old, eb.old);
        chk("b_done_cycle", cyc, eb.cyc);
        chk("b_wb_wen", {127'd0, ram_if.wen}, {127'd0, eb.wen});
        if (eb.wen) begin
          chk("b_wb_wadr", ram_if.wadr, eb.adr);
          chk("b_wb_wdat", ram_if.wdat, eb.nv);
        end
      end
    end
    if (quiet) chk("quiet_after_rst", {126'd0, b_done, ram_if.wen}, 0);
  end

  task automatic issue_a(input logic we, input logic [AW-1:0] adr, input logic [DW-1:0] dat, output int gcyc);
    int n = 0;
    a_vld = 1'b1; a_we = we; a_adr = adr; a_wdat = dat;
    gcyc = -1;
    while (gcyc < 0) begin
      @(negedge clk);
      if (a_rdy) gcyc = cyc;
      n++;
      @(posedge clk); #1;
      if (gcyc < 0 && n > 64) begin
        n_chk++; n_fail++;
        $display("FAIL a_grant_timeout: no a_rdy after %0d cycles", n);
        break;
      end
    end
    a_vld = 1'b0;
  endtask

  task automatic issue_b(input logic [AW-1:0] adr, input logic [15:0] pidx, output int gcyc);
    int n = 0;
    b_vld = 1'b1; b_adr = adr; b_pidx = pidx;
    gcyc = -1;
    while (gcyc < 0) begin
      @(negedge clk);
      if (b_rdy) gcyc = cyc;
      n++;
      @(posedge clk); #1;
      if (gcyc < 0 && n > 64) begin
        n_chk++; n_fail++;
        $display("FAIL b_grant_timeout: no b_rdy after %0d cycles", n);
        break;
      end
    end
    b_vld = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_a.size() != 0 || exp_b.size() != 0) && n < 64) begin
      @(posedge clk); #1;
      n++;
    end
    if (exp_a.size() != 0 || exp_b.size() != 0) begin
      n_chk++; n_fail++;
      $display("FAIL drain_timeout: %0d A and %0d B responses outstanding", exp_a.size(), exp_b.size());
      exp_a.delete(); exp_b.delete();
    end
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int g[4];
    int gx;
    int nmis;
    logic [DW-1:0] d, save;
    logic [AW-1:0] pool [8];
    pool = '{11'h000, 11'h001, 11'h005, 11'h100, 11'h3C3, 11'h7FE, 11'h7FF, 11'h040};
    rst = 1'b1; a_vld = 0; a_we = 0; a_adr = '0; a_wdat = '0;
    b_vld = 0; b_adr = '0; b_pidx = '0;
    init_we = 0; init_adr = '0; init_dat = '0; inj_sbe = 0; inj_dbe = 0;
`ifdef MDMA_WRB_CTXT_RAM_ECC_ERR_EN
    err_clr = 0;
`endif
    for (int i = 0; i < WRB_CTXT_RAM_DEPTH; i++) begin
      @(posedge clk); #1;
      init_we = 1'b1; init_adr = AW'(i); init_dat = rand128(); ref_mem[i] = init_dat;
    end
    @(posedge clk); #1;
    init_we = 1'b0;

    // reset state, with requests present to prove grants are blocked
    a_vld = 1'b1; b_vld = 1'b1;
    @(negedge clk);
    chk("rst_a_rdy", {127'd0, a_rdy}, 0);
    chk("rst_b_rdy", {127'd0, b_rdy}, 0);
    chk("rst_a_rvld", {127'd0, a_rvld}, 0);
    chk("rst_b_done", {127'd0, b_done}, 0);
    chk("rst_ren_wen", {126'd0, ram_if.ren, ram_if.wen}, 0);
    chk("rst_a_rdat", a_rdat, 0);
    chk("rst_b_old", b_old, 0);
    @(posedge clk); #1;
    a_vld = 1'b0; b_vld = 1'b0; rst = 1'b0;

    // A write then A read in the following cycle
    issue_a(1'b1, 11'h005, {16{8'hA5}}, g[0]);
    issue_a(1'b0, 11'h005, '0, g[1]);
    chk("a_wr_rd_b2b", g[1] - g[0], 1);
    drain();

    // B read-modify-write of pidx, then read back
    d = rand128(); d[15:0] = 16'h1234;
    issue_a(1'b1, 11'h100, d, gx);
    issue_b(11'h100, 16'hBEEF, gx);
    issue_a(1'b0, 11'h100, '0, gx);
    drain();

    // contention straight after reset: A, B, A, B
    do_reset();
    gnt_seq.delete();
    fork
      begin issue_a(1'b1, 11'h020, rand128(), g[0]); issue_a(1'b1, 11'h021, rand128(), g[1]); end
      begin issue_b(11'h030, 16'h1111, g[2]); issue_b(11'h031, 16'h2222, g[3]); end
    join
    drain();
    chk("rr_grant_count", gnt_seq.size(), 4);
    if (gnt_seq.size() >= 4)
      chk("rr_order", {124'd0, gnt_seq[0], gnt_seq[1], gnt_seq[2], gnt_seq[3]}, 4'b0101);

    // four back-to-back writes at the address extremes, then read back
    issue_a(1'b1, 11'h7FF, rand128(), g[0]);
    issue_a(1'b1, 11'h000, rand128(), g[1]);
    issue_a(1'b1, 11'h001, rand128(), g[2]);
    issue_a(1'b1, 11'h7FE, rand128(), g[3]);
    for (int i = 1; i < 4; i++) chk("a_wr_rate", g[i] - g[i-1], 1);
    issue_a(1'b0, 11'h7FF, '0, gx);
    issue_a(1'b0, 11'h000, '0, gx);
    issue_a(1'b0, 11'h001, '0, gx);
    issue_a(1'b0, 11'h7FE, '0, gx);
    drain();

    // reset one cycle after a B grant: the RMW must vanish
    save = ref_mem[11'h040];
    issue_b(11'h040, 16'h5A5A, gx);
    rst = 1'b1; quiet = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b0;
    exp_b.delete();
    ref_mem[11'h040] = save;
    a_vld = 1'b1; a_we = 1'b0; a_adr = 11'h040;
    @(negedge clk);
    chk("a_rdy_after_rst", {127'd0, a_rdy}, 1);
    @(posedge clk); #1;
    a_vld = 1'b0;
    drain();
    quiet = 1'b0;
    chk("rst_entry_unchanged", ram_mem[11'h040], save);

`ifdef MDMA_WRB_CTXT_RAM_ECC_ERR_EN
    save = ref_mem[11'h010];
    inj_dbe = 1'b1;
    issue_b(11'h010, 16'hCAFE, gx);
    inj_dbe = 1'b0;
    drain();
    chk("dbe_err", {127'd0, dbe_err}, 1);
    chk("dbe_adr", dbe_adr, 11'h010);
    chk("dbe_entry_unchanged", ram_mem[11'h010], save);
    inj_sbe = 1'b1;
    for (int i = 0; i < 3; i++) issue_a(1'b0, pool[i], '0, gx);
    inj_sbe = 1'b0;
    drain();
    chk("sbe_cnt", sbe_cnt, 3);
    err_clr = 1'b1;
    @(posedge clk); #1;
    err_clr = 1'b0;
    chk("err_clr", {sbe_cnt, dbe_err, dbe_adr}, 0);
`endif

    // randomized concurrent traffic over a small address pool
    fork
      for (int i = 0; i < 120; i++) begin
        repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        issue_a(1'($urandom_range(0, 1)), pool[$urandom_range(0, 7)], rand128(), gx);
      end
      for (int i = 0; i < 80; i++) begin
        repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
        issue_b(pool[$urandom_range(0, 7)], 16'($urandom_range(0, 65535)), gx);
      end
    join
    drain();

    chk("no_ren_wen_overlap", overlap_cnt, 0);
    nmis = 0;
    for (int i = 0; i < WRB_CTXT_RAM_DEPTH; i++)
      if (ram_mem[i] !== ref_mem[i]) nmis++;
    chk("ram_contents", nmis, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
